// File: rtl/latch_bank_wr_ctrl.sv
// Write-side sequencer for a bank of positive-gate transparent latches.
// It accepts one write at a time over valid/ready. For each write it drives
// the data bus through three phases: setup, a one-hot gate pulse, and hold.
// On request it also pulses a bank-wide clear. It is the only driver of the
// bank's D, G and CLR pins, and every pin comes straight from a flop.
module latch_bank_wr_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 2,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              clr_req,
  output logic              busy,
  output logic              addr_err,
  output logic [WIDTH-1:0]  ld,
  output logic [DEPTH-1:0]  lg,
  output logic              lclr
);

  // The phase counter is loaded with (length - 1) on phase entry and counts
  // down to zero. It therefore only needs to hold values below the longest
  // phase length.
  localparam int MAX_CYC_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC    = (MAX_CYC_SP > HOLD_CYC) ? MAX_CYC_SP : HOLD_CYC;
  localparam int CNT_W      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'((PULSE_CYC > 0) ? PULSE_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  // The address is compared one bit wider so that DEPTH == 2**ADDR_W is still
  // representable. Any address at or above DEPTH has no gate line.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_CLEAR
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               clr_pending_q, clr_pending_d;
  logic [WIDTH-1:0]   ld_q, ld_d;
  logic [DEPTH-1:0]   lg_q, lg_d;
  logic               lclr_q, lclr_d;
  logic               addr_err_q, addr_err_d;
  logic               accept;
  logic               addr_oob;

  // Handshake and status decode. A clear request, whether live or deferred,
  // blocks acceptance so that the clear always wins over a simultaneous write.
  assign wr_ready = (state_q == ST_IDLE) && !clr_req && !clr_pending_q;
  assign busy     = (state_q != ST_IDLE);
  assign accept   = wr_valid && wr_ready;
  assign addr_oob = ({1'b0, wr_addr} >= DEPTH_X);

  assign ld       = ld_q;
  assign lg       = lg_q;
  assign lclr     = lclr_q;
  assign addr_err = addr_err_q;

  // Next-state, phase counter, captured request and next values of the pin flops.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    clr_pending_d = clr_pending_q;
    ld_d          = ld_q;
    addr_err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (clr_req || clr_pending_q) begin
          state_d       = ST_CLEAR;
          cnt_d         = PULSE_LOAD;
          clr_pending_d = 1'b0;
        end else if (accept) begin
          addr_d     = wr_addr;
          ld_d       = wr_data;
          addr_err_d = addr_oob;
          if (SETUP_CYC > 0) begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LOAD;
          end else begin
            state_d = ST_PULSE;
            cnt_d   = PULSE_LOAD;
          end
        end
      end

      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = PULSE_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_PULSE: begin
        if (cnt_q == '0) begin
          if (HOLD_CYC > 0) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LOAD;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_CLEAR: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A clear requested while a write is in flight is deferred. The write
    // finishes untouched. A request seen during a clear merges into that clear.
    if (clr_req && (state_q inside {ST_SETUP, ST_PULSE, ST_HOLD})) begin
      clr_pending_d = 1'b1;
    end

    // The pin values come from the next state, so the gate and clear flops
    // switch on the same edge as the state they belong to. An out-of-range
    // address matches no gate line and leaves lg all zero.
    lclr_d = (state_d == ST_CLEAR);
    for (int i = 0; i < DEPTH; i++) begin
      lg_d[i] = (state_d == ST_PULSE) && (int'(addr_d) == i);
    end
  end

  // State and pin registers. Reset drops gate and clear at the same edge,
  // abandons any write and discards a deferred clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      clr_pending_q <= 1'b0;
      ld_q          <= '0;
      lg_q          <= '0;
      lclr_q        <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      clr_pending_q <= clr_pending_d;
      ld_q          <= ld_d;
      lg_q          <= lg_d;
      lclr_q        <= lclr_d;
      addr_err_q    <= addr_err_d;
    end
  end

endmodule
